// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch buffer.
package fetch_pkg;

  localparam int FETCH_AW   = 8;
  localparam int FETCH_ILEN = 16;

  typedef struct packed {
    logic [FETCH_AW-1:0]   pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;

  // Width needed to hold an occupancy value from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 3,
  localparam int CW    = count_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wrap_inc(wr_q);
      if (pop_i)  rd_q <= wrap_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i && !flush_i) mem_q[wr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  push_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues PC to synchronous imem, buffers returned instructions for decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int  AW    = FETCH_AW,
  parameter int  ILEN  = FETCH_ILEN,
  parameter int  DEPTH = 3,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   pc_i,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [AW-1:0]   imem_addr_o,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            stall_o,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [ILEN-1:0] id_instr_o,
  output logic [AW-1:0]   id_pc_o
);

  logic          inflight_q;
  logic [AW-1:0] inflight_pc_q;
  logic [CW-1:0] count;
  logic          occupancy_full;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Stall counts the in-flight fetch as occupied so its response always has a slot.
  assign occupancy_full = ({1'b0, count} + {{CW{1'b0}}, inflight_q}) >= (CW + 1)'(DEPTH);
  assign stall_o        = !rst_i && occupancy_full;
  assign imem_req_o     = !rst_i && !stall_o && !flush_i;
  assign imem_addr_o    = pc_i;

  assign push             = inflight_q && !flush_i && !rst_i;
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_rdata_i;

  assign id_valid_o = !rst_i && !flush_i && (count != '0);
  assign pop        = id_valid_o && id_ready_i;
  assign id_instr_o = rst_i ? '0 : head.instr;
  assign id_pc_o    = rst_i ? '0 : head.pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) inflight_pc_q <= pc_i;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-based reference of the fetch stage.
module tb_fetch_buffer;

  localparam int NCYC = 600;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  pc_i;
  logic        flush_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic [15:0] imem_rdata_i;
  logic        stall_o;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [15:0] id_instr_o;
  logic [7:0]  id_pc_o;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic [15:0] mem [128];
  exp_t        q[$];
  bit          m_inflight;
  logic [7:0]  m_inflight_pc;
  logic [7:0]  pc;
  logic [7:0]  target;
  int          pass_count = 0;
  int          check_count = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.AW(8), .ILEN(16), .DEPTH(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .stall_o      (stall_o),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o)
  );

  // Synchronous instruction memory: data for the address presented arrives next cycle.
  always @(posedge clk) imem_rdata_i <= mem[imem_addr_o[7:1]];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit rdy);
    rst_i      = r;
    flush_i    = f;
    id_ready_i = rdy;
    pc_i       = pc;
  endtask

  initial begin
    bit r, f, rdy, e_stall, e_req, e_valid, s_stall;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    pc = 8'h00;
    target = 8'h40;
    m_inflight = 0;
    m_inflight_pc = '0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    for (int c = 0; c < NCYC; c++) begin
      r = (c < 2) || c == 200 || c == 300 || (c >= 61 && $urandom_range(0, 59) == 0);
      f = c == 40 || c == 50 || c == 200 || (c >= 61 && $urandom_range(0, 11) == 0);
      if (c < 31)      rdy = 1'b1;
      else if (c < 46) rdy = 1'b0;
      else if (c < 61) rdy = 1'b1;
      else             rdy = ($urandom_range(0, 3) != 0);
      if (f) target = {7'($urandom_range(0, 127)), 1'b0};
      applyStimulus(r, f, rdy);

      @(negedge clk);
      e_stall = !r && ((q.size() + int'(m_inflight)) >= 3);
      e_req   = !r && !e_stall && !f;
      e_valid = !r && !f && q.size() > 0;
      checkOutput("stall", 32'(stall_o), 32'(e_stall), c);
      checkOutput("req", 32'(imem_req_o), 32'(e_req), c);
      checkOutput("valid", 32'(id_valid_o), 32'(e_valid), c);
      if (e_req) checkOutput("addr", 32'(imem_addr_o), 32'(pc), c);
      if (r) begin
        checkOutput("rst_pc", 32'(id_pc_o), 32'h0, c);
        checkOutput("rst_instr", 32'(id_instr_o), 32'h0, c);
      end else if (e_valid) begin
        checkOutput("head_pc", 32'(id_pc_o), 32'(q[0].pc), c);
        checkOutput("head_instr", 32'(id_instr_o), 32'(q[0].instr), c);
      end
      s_stall = stall_o;

      @(posedge clk); #1;
      if (r || f) begin
        q.delete();
        m_inflight = 0;
      end else begin
        if (e_valid && rdy) void'(q.pop_front());
        if (m_inflight) q.push_back('{pc: m_inflight_pc, instr: mem[m_inflight_pc[7:1]]});
        m_inflight    = e_req;
        m_inflight_pc = pc;
      end
      if (r)            pc = pc;
      else if (f)       pc = target;
      else if (!s_stall) pc = pc + 8'd2;
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
